// File: rtl/multi_phase_traffic_controller.sv
// Round-robin traffic controller for NUM_DIR approaches with tick-paced countdown,
// 7-segment readout and manual override. Optional pedestrian walk phase: define PED_WALK_EN.
module multi_phase_traffic_controller #(
    parameter int  NUM_DIR      = 2,
    parameter int  TICK_DIV     = 100000000,
    parameter int  GREEN_TIME   = 9,
    parameter int  YELLOW_TIME  = 3,
    parameter int  ALL_RED_TIME = 1,
    parameter int  WALK_TIME    = 5,
    localparam int DIR_W        = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               manual_override,
    input  logic [1:0]         manual_state,
    input  logic [DIR_W-1:0]   manual_dir,
`ifdef PED_WALK_EN
    input  logic               ped_req,
    output logic               walk,
`endif
    output logic [NUM_DIR-1:0] R,
    output logic [NUM_DIR-1:0] Y,
    output logic [NUM_DIR-1:0] G,
    output logic [3:0]         time_remaining,
    output logic [7:0]         seg
);

    localparam int               PRE_W      = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [DIR_W-1:0] PHASE_LAST = DIR_W'(NUM_DIR - 1);

    typedef enum logic [2:0] {
        S_GREEN,
        S_YELLOW,
        S_ALL_RED,
        S_MANUAL
`ifdef PED_WALK_EN
        , S_WALK
`endif
    } state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [DIR_W-1:0]   phase_q, phase_d, phase_next;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [3:0]         time_q, time_d;
    logic [NUM_DIR-1:0] r_q, r_d, y_q, y_d, g_q, g_d;
    logic [7:0]         seg_q, seg_d;
    logic               tick;
    logic               man_dir_ok;
`ifdef PED_WALK_EN
    logic               pend_q, pend_d;
    logic               walk_q, walk_d;
`endif

    assign tick       = (presc_q == PRE_LAST);
    assign phase_next = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    assign man_dir_ok = (32'(manual_dir) < NUM_DIR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ALL_RED;
            phase_q <= PHASE_LAST;
            presc_q <= '0;
            time_q  <= 4'(ALL_RED_TIME);
            r_q     <= '1;
            y_q     <= '0;
            g_q     <= '0;
            seg_q   <= {1'b0, seg_digit(4'(ALL_RED_TIME))};
`ifdef PED_WALK_EN
            pend_q  <= 1'b0;
            walk_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            time_q  <= time_d;
            r_q     <= r_d;
            y_q     <= y_d;
            g_q     <= g_d;
            seg_q   <= seg_d;
`ifdef PED_WALK_EN
            pend_q  <= pend_d;
            walk_q  <= walk_d;
`endif
        end
    end

    // Override beats any tick; leaving MANUAL always recovers through a fresh ALL_RED.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        presc_d = presc_q;
        time_d  = time_q;
`ifdef PED_WALK_EN
        pend_d  = pend_q | ped_req;
`endif
        if (manual_override) begin
            state_d = S_MANUAL;
            presc_d = '0;
            time_d  = '0;
        end else if (state_q == S_MANUAL) begin
            state_d = S_ALL_RED;
            presc_d = '0;
            time_d  = 4'(ALL_RED_TIME);
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (time_q > 4'd1) begin
                    time_d = time_q - 4'd1;
                end else begin
                    case (state_q)
                        S_GREEN: begin
                            state_d = S_YELLOW;
                            time_d  = 4'(YELLOW_TIME);
                        end
                        S_YELLOW: begin
                            state_d = S_ALL_RED;
                            time_d  = 4'(ALL_RED_TIME);
                        end
                        S_ALL_RED: begin
`ifdef PED_WALK_EN
                            if (pend_q) begin
                                state_d = S_WALK;
                                time_d  = 4'(WALK_TIME);
                                pend_d  = ped_req;
                            end else begin
                                state_d = S_GREEN;
                                phase_d = phase_next;
                                time_d  = 4'(GREEN_TIME);
                            end
`else
                            state_d = S_GREEN;
                            phase_d = phase_next;
                            time_d  = 4'(GREEN_TIME);
`endif
                        end
`ifdef PED_WALK_EN
                        S_WALK: begin
                            state_d = S_GREEN;
                            phase_d = phase_next;
                            time_d  = 4'(GREEN_TIME);
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        r_d = '1;
        y_d = '0;
        g_d = '0;
        case (state_d)
            S_GREEN: begin
                g_d[phase_d] = 1'b1;
                r_d[phase_d] = 1'b0;
            end
            S_YELLOW: begin
                y_d[phase_d] = 1'b1;
                r_d[phase_d] = 1'b0;
            end
            S_MANUAL: begin
                if (man_dir_ok) begin
                    case (manual_state)
                        2'b01: begin
                            y_d[manual_dir] = 1'b1;
                            r_d[manual_dir] = 1'b0;
                        end
                        2'b10: begin
                            g_d[manual_dir] = 1'b1;
                            r_d[manual_dir] = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        seg_d = {state_d == S_MANUAL, seg_digit(time_d)};
`ifdef PED_WALK_EN
        walk_d = (state_d == S_WALK);
`endif
    end

    assign R              = r_q;
    assign Y              = y_q;
    assign G              = g_q;
    assign time_remaining = time_q;
    assign seg            = seg_q;
`ifdef PED_WALK_EN
    assign walk           = walk_q;
`endif

endmodule
